// File: rtl/fx_pkg.sv
// Shared encodings and width helpers for the fixed-point requantizer blocks.
package fx_pkg;

  localparam int FX_QUAN_TRUNC = 0;
  localparam int FX_QUAN_RND   = 1;
  localparam int FX_OVF_WRAP   = 0;
  localparam int FX_OVF_SAT    = 1;

  function automatic int fx_total_w(input int iw, input int fw);
    return iw + fw;
  endfunction

  // One spare integer bit above the input range holds the round-up carry.
  function automatic int fx_qw(input int in_iw, input int out_fw);
    return in_iw + 1 + out_fw;
  endfunction

endpackage

// File: rtl/fx_ovf_stage.sv
// Combinational MSB alignment: range check, saturate or wrap, overflow flag.
module fx_ovf_stage
  import fx_pkg::*;
#(
  parameter int QW       = 11,
  parameter int OUT_W    = 8,
  parameter int OVF_MODE = FX_OVF_SAT
) (
  input  logic signed [QW-1:0]    i_q,
  output logic        [OUT_W-1:0] o_data,
  output logic                    o_ovf
);

  generate
    if (OUT_W >= QW) begin : g_fits
      always_comb begin
        o_ovf  = 1'b0;
        o_data = OUT_W'(i_q);
      end
    end else begin : g_check
      localparam int HW = QW - OUT_W + 1;
      logic [HW-1:0] head;

      // In range exactly when every bit from the output sign bit upward agrees.
      always_comb begin
        head   = i_q[QW-1:OUT_W-1];
        o_ovf  = !((&head) || (~|head));
        o_data = i_q[OUT_W-1:0];
        if (o_ovf && (OVF_MODE == FX_OVF_SAT)) begin
          o_data = i_q[QW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
      end
    end
  endgenerate

endmodule

// File: rtl/fx_requant_pipe.sv
// Two-stage fixed-point requantizer (quantize, then overflow) with
// valid/ready backpressure and overflow event reporting.
module fx_requant_pipe
  import fx_pkg::*;
#(
  parameter int IN_IW     = 4,
  parameter int IN_FW     = 9,
  parameter int OUT_IW    = 2,
  parameter int OUT_FW    = 6,
  parameter int QUAN_MODE = FX_QUAN_RND,
  parameter int OVF_MODE  = FX_OVF_SAT,
  parameter int CNT_W     = 16,
  localparam int IN_W     = fx_total_w(IN_IW, IN_FW),
  localparam int OUT_W    = fx_total_w(OUT_IW, OUT_FW),
  localparam int QW       = fx_qw(IN_IW, OUT_FW)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic signed [IN_W-1:0]  i_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic signed [OUT_W-1:0] o_data,
  output logic                    o_ovf,
  output logic                    o_ovf_sticky,
  input  logic                    i_clr,
  output logic [CNT_W-1:0]        o_ovf_cnt
);

  // Handshake: a word moves when valid && ready on a rising edge. A stage
  // loads when it is empty or its content leaves this cycle, so o_ready
  // depends combinationally on i_ready; a stalled output holds data and flag.

  logic signed [QW-1:0] q_val;

  generate
    if (OUT_FW >= IN_FW) begin : g_widen
      always_comb q_val = QW'(i_data) <<< (OUT_FW - IN_FW);
    end else begin : g_narrow
      localparam int D = IN_FW - OUT_FW;
      localparam logic signed [IN_W:0] HALF =
        (QUAN_MODE == FX_QUAN_RND) ? ((IN_W+1)'(1) <<< (D - 1)) : '0;
      logic signed [IN_W:0] sum;

      always_comb begin
        sum   = (IN_W+1)'(i_data) + HALF;
        q_val = QW'(sum >>> D);
      end
    end
  endgenerate

  logic                 s1_valid_q, s1_valid_d;
  logic signed [QW-1:0] s1_data_q, s1_data_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [OUT_W-1:0]     s2_data_q, s2_data_d;
  logic                 s2_ovf_q, s2_ovf_d;
  logic                 sticky_q, sticky_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OUT_W-1:0]     ovf_data;
  logic                 ovf_flag;
  logic                 s1_en, s2_en, ovf_evt;

  fx_ovf_stage #(
    .QW       (QW),
    .OUT_W    (OUT_W),
    .OVF_MODE (OVF_MODE)
  ) u_ovf (
    .i_q    (s1_data_q),
    .o_data (ovf_data),
    .o_ovf  (ovf_flag)
  );

  always_comb begin
    s2_en      = !s2_valid_q || i_ready;
    s1_en      = !s1_valid_q || s2_en;
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_ovf_d   = s2_ovf_q;
    sticky_d   = sticky_q;
    cnt_d      = cnt_q;
    ovf_evt    = s2_valid_q && i_ready && s2_ovf_q;

    if (s1_en) begin
      s1_valid_d = i_valid;
      if (i_valid) s1_data_d = q_val;
    end
    if (s2_en) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = ovf_data;
        s2_ovf_d  = ovf_flag;
      end
    end

    // A clear that coincides with a counted event keeps that event.
    if (i_clr) begin
      sticky_d = ovf_evt;
      cnt_d    = ovf_evt ? CNT_W'(1) : '0;
    end else if (ovf_evt) begin
      sticky_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_ovf_q   <= 1'b0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_ovf_q   <= s2_ovf_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_ready      = s1_en;
  assign o_valid      = s2_valid_q;
  assign o_data       = s2_data_q;
  assign o_ovf        = s2_ovf_q;
  assign o_ovf_sticky = sticky_q;
  assign o_ovf_cnt    = cnt_q;

endmodule

// File: tb/tb_fx_requant_pipe.sv
// Bench for fx_requant_pipe: three mode variants share one stimulus stream,
// directed steps plus a random phase checked against an arithmetic model.
module tb_fx_requant_pipe;
  import fx_pkg::*;

  localparam int IN_W  = 13;
  localparam int OUT_W = 8;
  localparam int CNT_W = 16;
  localparam int SH    = 3;  // input fraction bits minus output fraction bits
  localparam int N     = 3;
  localparam int EW    = OUT_W + 1;

  logic clk = 1'b0;
  logic rst_n, i_valid, i_ready, i_clr;
  logic [IN_W-1:0]  i_data;
  logic             o_ready [N];
  logic             o_valid [N];
  logic             o_ovf   [N];
  logic             o_stk   [N];
  logic [OUT_W-1:0] o_data  [N];
  logic [CNT_W-1:0] o_cnt   [N];

  int checks   = 0;
  int failures = 0;

  logic [N*EW-1:0] exp_q[$];
  int   mdl_cnt [N];
  logic mdl_stk [N];

  always #5 clk = ~clk;

  // Variant 0: round + saturate, 1: truncate + saturate, 2: round + wrap.
  fx_requant_pipe #(.QUAN_MODE(FX_QUAN_RND), .OVF_MODE(FX_OVF_SAT)) u_rs (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready[0]),
    .i_data(i_data), .o_valid(o_valid[0]), .i_ready(i_ready), .o_data(o_data[0]),
    .o_ovf(o_ovf[0]), .o_ovf_sticky(o_stk[0]), .i_clr(i_clr), .o_ovf_cnt(o_cnt[0]));

  fx_requant_pipe #(.QUAN_MODE(FX_QUAN_TRUNC), .OVF_MODE(FX_OVF_SAT)) u_ts (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready[1]),
    .i_data(i_data), .o_valid(o_valid[1]), .i_ready(i_ready), .o_data(o_data[1]),
    .o_ovf(o_ovf[1]), .o_ovf_sticky(o_stk[1]), .i_clr(i_clr), .o_ovf_cnt(o_cnt[1]));

  fx_requant_pipe #(.QUAN_MODE(FX_QUAN_RND), .OVF_MODE(FX_OVF_WRAP)) u_rw (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready[2]),
    .i_data(i_data), .o_valid(o_valid[2]), .i_ready(i_ready), .o_data(o_data[2]),
    .o_ovf(o_ovf[2]), .o_ovf_sticky(o_stk[2]), .i_clr(i_clr), .o_ovf_cnt(o_cnt[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Real-valued rule: value * 2^OUT_FW, optional +0.5 LSB, floor, then range.
  function automatic logic [EW-1:0] ref_out(input logic [IN_W-1:0] d, input int k);
    int v;
    logic ovf;
    logic [OUT_W-1:0] r;
    v = $signed(d);
    if (k != 1) v = v + (1 << (SH - 1));
    v   = v >>> SH;
    ovf = (v > 127) || (v < -128);
    r   = v[OUT_W-1:0];
    if (ovf && k != 2) r = (v > 0) ? 8'h7F : 8'h80;
    return {ovf, r};
  endfunction

  function automatic logic [N*EW-1:0] ref_all(input logic [IN_W-1:0] d);
    logic [N*EW-1:0] p;
    for (int k = 0; k < N; k++) p[k*EW +: EW] = ref_out(d, k);
    return p;
  endfunction

  // Scoreboard and counter model, sampled on the falling edge.
  always @(negedge clk) begin
    logic [N*EW-1:0] e;
    logic evt [N];
    if (!rst_n) begin
      exp_q.delete();
      for (int k = 0; k < N; k++) begin
        mdl_cnt[k] = 0;
        mdl_stk[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        check($sformatf("cnt%0d", k), 32'(o_cnt[k]), 32'(mdl_cnt[k]));
        check($sformatf("sticky%0d", k), 32'(o_stk[k]), 32'(mdl_stk[k]));
        evt[k] = 1'b0;
      end
      if (o_valid[0] && i_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          for (int k = 0; k < N; k++) begin
            check($sformatf("sb_valid%0d", k), 32'(o_valid[k]), 32'd1);
            check($sformatf("sb_data%0d", k), 32'(o_data[k]), 32'(e[k*EW +: OUT_W]));
            check($sformatf("sb_ovf%0d", k), 32'(o_ovf[k]), 32'(e[k*EW + OUT_W]));
            evt[k] = e[k*EW + OUT_W];
          end
        end
      end
      if (i_valid && o_ready[0]) exp_q.push_back(ref_all(i_data));
      for (int k = 0; k < N; k++) begin
        if (i_clr) begin
          mdl_cnt[k] = evt[k] ? 1 : 0;
          mdl_stk[k] = evt[k];
        end else if (evt[k]) begin
          mdl_stk[k] = 1'b1;
          if (mdl_cnt[k] < (1 << CNT_W) - 1) mdl_cnt[k] = mdl_cnt[k] + 1;
        end
      end
    end
  end

  task automatic send(input logic [IN_W-1:0] d);
    int n = 0;
    @(posedge clk); #1;
    i_valid = 1'b1;
    i_data  = d;
    @(negedge clk);
    while (!o_ready[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready[0]) check("send_timeout", 32'(o_ready[0]), 32'd1);
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    @(negedge clk);
    while (!o_valid[0] && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!o_valid[0]) check("wait_out_timeout", 32'(o_valid[0]), 32'd1);
  endtask

  initial begin
    logic [7:0] bp_exp [3];
    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_clr = 1'b0; i_data = '0;
    bp_exp[0] = 8'h01; bp_exp[1] = 8'h02; bp_exp[2] = 8'h03;

    // Reset state
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check("rst_valid", 32'(o_valid[k]), 32'd0);
      check("rst_data", 32'(o_data[k]), 32'd0);
      check("rst_ovf", 32'(o_ovf[k]), 32'd0);
      check("rst_sticky", 32'(o_stk[k]), 32'd0);
      check("rst_cnt", 32'(o_cnt[k]), 32'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic rounding with two-cycle latency
    @(posedge clk); #1;
    i_valid = 1'b1; i_data = 13'h0004;
    @(posedge clk); #1 i_valid = 1'b0;
    @(negedge clk);
    check("lat_not_yet", 32'(o_valid[0]), 32'd0);
    @(negedge clk);
    check("lat_valid", 32'(o_valid[0]), 32'd1);
    check("round_data", 32'(o_data[0]), 32'h01);
    check("round_ovf", 32'(o_ovf[0]), 32'd0);
    check("trunc_data", 32'(o_data[1]), 32'h00);

    // Positive saturation and wrap
    send(13'h0FFF);
    wait_out();
    check("psat_data", 32'(o_data[0]), 32'h7F);
    check("psat_ovf", 32'(o_ovf[0]), 32'd1);
    check("pwrap_data", 32'(o_data[2]), 32'h00);
    check("pwrap_ovf", 32'(o_ovf[2]), 32'd1);
    @(negedge clk);
    check("psat_cnt", 32'(o_cnt[0]), 32'd1);

    // Round-up carry overflow and negative limit
    send(13'h03FF);
    wait_out();
    check("carry_data", 32'(o_data[0]), 32'h7F);
    check("carry_ovf", 32'(o_ovf[0]), 32'd1);
    check("carry_trunc_ovf", 32'(o_ovf[1]), 32'd0);
    send(13'h1000);
    wait_out();
    check("nsat_data", 32'(o_data[0]), 32'h80);
    check("nsat_ovf", 32'(o_ovf[0]), 32'd1);

    // Backpressure: fill both stages, stall three cycles, then drain in order
    @(posedge clk); #1;
    i_ready = 1'b0; i_valid = 1'b1; i_data = 13'h0008;
    @(posedge clk); #1 i_data = 13'h0010;
    @(posedge clk); #1 i_data = 13'h0018;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_ready_low", 32'(o_ready[0]), 32'd0);
      check("bp_hold_valid", 32'(o_valid[0]), 32'd1);
      check("bp_hold_data", 32'(o_data[0]), 32'h01);
    end
    @(posedge clk); #1 i_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_back", 32'(o_ready[0]), 32'd1);
    check("bp_out0", 32'(o_data[0]), 32'(bp_exp[0]));
    @(posedge clk); #1 i_valid = 1'b0;
    for (int j = 1; j < 3; j++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(o_valid[0]), 32'd1);
      check($sformatf("bp_out%0d", j), 32'(o_data[0]), 32'(bp_exp[j]));
    end

    // Clear collision: count reaches 5, then clear on the 6th event
    send(13'h0FFF); wait_out();
    send(13'h0FFF); wait_out();
    @(negedge clk);
    check("pre_clr_cnt", 32'(o_cnt[0]), 32'd5);
    @(posedge clk); #1 i_ready = 1'b0;
    send(13'h0FFF);
    wait_out();
    @(posedge clk); #1;
    i_clr = 1'b1; i_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("clr_evt_cnt", 32'(o_cnt[0]), 32'd1);
    check("clr_evt_sticky", 32'(o_stk[0]), 32'd1);
    @(posedge clk); #1 i_clr = 1'b0;
    @(negedge clk);
    check("clr_only_cnt", 32'(o_cnt[0]), 32'd0);
    check("clr_only_sticky", 32'(o_stk[0]), 32'd0);

    // Random traffic with random backpressure and occasional clears
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 3) != 0);
      i_clr   = ($urandom_range(0, 15) == 0);
      i_data  = IN_W'($urandom_range(0, (1 << IN_W) - 1));
    end
    @(posedge clk); #1;
    i_valid = 1'b0; i_ready = 1'b1; i_clr = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    // Reset with two samples in flight
    send(13'h0FFF);
    wait_out();
    @(negedge clk);
    check("pre_rst_sticky", 32'(o_stk[0]), 32'd1);
    @(posedge clk); #1;
    i_ready = 1'b0; i_valid = 1'b1; i_data = 13'h0008;
    @(posedge clk); #1 i_data = 13'h0010;
    @(posedge clk); #1 i_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", 32'(o_valid[0]), 32'd1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      check("mid_rst_valid", 32'(o_valid[k]), 32'd0);
      check("mid_rst_data", 32'(o_data[k]), 32'd0);
      check("mid_rst_ovf", 32'(o_ovf[k]), 32'd0);
      check("mid_rst_sticky", 32'(o_stk[k]), 32'd0);
      check("mid_rst_cnt", 32'(o_cnt[k]), 32'd0);
    end
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1; i_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(o_valid[0]), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
